cpu_run_ctrl: RTL

CPU execution controller that gates CPU advancement through a single clock-enable pulse, `cpu_ce`. It supports halt, single-step, rate-divided free-run, and a PC breakpoint. It sits between the debounced switch/button outputs and the CPU, replacing the ad-hoc STEP/clock-divide path. It also keeps a retired-instruction count for display on the seven-segment multiplexer.

---
 rtl/cpu_run_pkg.sv | 35 +++
 rtl/run_rate_div.sv | 50 +++++
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_pkg
//   Shared definitions for the CPU run controller: FSM state encodings, the
//   free-run divider limits and a helper that maps rate_sel to a divider limit.
// -----------------------------------------------------------------------------
package cpu_run_pkg;

    // Encodings are visible on the 'state' output, so they are fixed values.
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_t;

    // Divider limits: a pulse is issued once div_cnt reaches the limit, so the
    // pulse spacing is limit + 1 cycles.
    localparam logic [31:0] LIMIT_FULL   = 32'd0;
    localparam logic [31:0] LIMIT_DIV256 = 32'd255;
    localparam logic [31:0] LIMIT_DIV64K = 32'd65535;

    // Slowest rate is one pulse per 2^div_w cycles.
    function automatic logic [31:0] rate_limit(input logic [1:0] rate_sel,
                                               input int unsigned div_w);
        logic [31:0] lim;
        case (rate_sel)
            2'd0:    lim = LIMIT_FULL;
            2'd1:    lim = LIMIT_DIV256;
            2'd2:    lim = LIMIT_DIV64K;
            default: lim = (div_w >= 32) ? '1 : ((32'd1 << div_w) - 32'd1);
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/run_rate_div.sv
// -----------------------------------------------------------------------------
// run_rate_div
//   Free-run rate divider. Counts cycles since the last CPU advance and raises
//   'tick' once the count reaches the limit selected by rate_sel.
//
// Ports
//   clk, RSTN  : clock, asynchronous active-low reset
//   rate_sel   : rate select (0 = every cycle, 1 = /256, 2 = /65536, 3 = /2^DIV_W)
//   load       : preload div_cnt with the limit (first pulse of a run is immediate)
//   clr        : restart counting (asserted on every cpu_ce)
//   tick       : div_cnt >= limit
//   div_cnt    : current divider count
// -----------------------------------------------------------------------------
module run_rate_div
    import cpu_run_pkg::*;
#(
    parameter int unsigned DIV_W = 20
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [1:0]       rate_sel,
    input  logic             load,
    input  logic             clr,
    output logic             tick,
    output logic [DIV_W-1:0] div_cnt
);

    logic [DIV_W-1:0] limit;

    assign limit = DIV_W'(rate_limit(rate_sel, DIV_W));

    // A greater-or-equal compare keeps a lowered rate_sel from stranding a
    // count that is already above the new limit.
    assign tick = (div_cnt >= limit);

    // Counting stops at the limit, so while hold blocks the pulse the count
    // saturates and the pulse fires on the first free cycle.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= limit;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   CPU execution controller. Gates CPU advancement through the single-cycle
//   clock enable cpu_ce, supporting halt, single-step, rate-divided free-run and
//   a PC breakpoint. Also counts retired instructions (cpu_ce pulses).
//
// Ports
//   clk, RSTN   : clock, asynchronous active-low reset
//   run_sw      : debounced level, 1 requests free-run
//   step_pulse  : debounced one-cycle pulse, requests one instruction
//   rate_sel    : free-run rate select
//   hold        : registered bus-busy, blocks cpu_ce
//   bp_en       : breakpoint enable
//   bp_addr     : breakpoint PC
//   pc          : CPU program counter (registered in the CPU)
//   cnt_clr     : clears instr_cnt
//   cpu_ce      : CPU advances on each clk edge where this is 1
//   halted      : 1 in HALT or BREAK
//   bp_hit      : 1 in BREAK
//   state       : current FSM state encoding
//   instr_cnt   : count of cpu_ce pulses, wraps
// -----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 20
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             run_sw,
    input  logic             step_pulse,
    input  logic [1:0]       rate_sel,
    input  logic             hold,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             cnt_clr,
    output logic             cpu_ce,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    run_state_t       cur_state;
    run_state_t       nxt_state;
    logic             skip;
    logic             bp_match;
    logic             enter_run;
    logic             tick;
    logic [DIV_W-1:0] div_cnt;

    run_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk      (clk),
        .RSTN     (RSTN),
        .rate_sel (rate_sel),
        .load     (enter_run),
        .clr      (cpu_ce),
        .tick     (tick),
        .div_cnt  (div_cnt)
    );

    assign bp_match  = bp_en && (pc == bp_addr);
    assign enter_run = (cur_state != ST_RUN) && (nxt_state == ST_RUN);
    assign state     = cur_state;

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_state = cur_state;
        cpu_ce    = 1'b0;
        case (cur_state)
            ST_HALT: begin
                // run_sw wins over a coincident step request.
                if (run_sw) begin
                    nxt_state = ST_RUN;
                end else if (step_pulse) begin
                    nxt_state = ST_STEP;
                end
            end
            ST_STEP: begin
                // No breakpoint check: a step from BREAK must execute bp_addr.
                if (!hold) begin
                    cpu_ce    = 1'b1;
                    nxt_state = ST_HALT;
                end
            end
            ST_RUN: begin
                if (!run_sw) begin
                    nxt_state = ST_HALT;
                end else if (bp_match && !skip) begin
                    nxt_state = ST_BREAK;
                end else if (tick && !hold) begin
                    cpu_ce = 1'b1;
                end
            end
            ST_BREAK: begin
                // Staying here with run_sw high forces a deliberate
                // lower-then-raise to resume free-run.
                if (step_pulse) begin
                    nxt_state = ST_STEP;
                end else if (!run_sw) begin
                    nxt_state = ST_HALT;
                end
            end
            default: nxt_state = ST_HALT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            cur_state <= ST_HALT;
            halted    <= 1'b1;
            bp_hit    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            halted    <= (nxt_state == ST_HALT) || (nxt_state == ST_BREAK);
            bp_hit    <= (nxt_state == ST_BREAK);
        end
    end

    // skip lets a resumed run execute the instruction sitting at bp_addr once;
    // it is dropped by the first advance of the run.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            skip <= 1'b0;
        end else if (enter_run) begin
            skip <= 1'b1;
        end else if (cpu_ce && (cur_state == ST_RUN)) begin
            skip <= 1'b0;
        end
    end

    // A clear coinciding with an advance still counts that advance.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            instr_cnt <= '0;
        end else if (cnt_clr) begin
            instr_cnt <= cpu_ce ? CNT_W'(1) : '0;
        end else if (cpu_ce) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule
